dispense_sequencer: RTL



---
 rtl/dispense_sequencer.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/dispense_sequencer.sv
// dispense_sequencer
//
// Opens the ingredient valves of the coffee machine one after another once
// the payment FSM has accepted a drink. The stages always run in the fixed
// order WATER > COFFEE > CHOC > MILK > SUGAR. Stages that the latched recipe
// does not use are skipped in zero cycles. A one-cycle DONE state then pulses
// `finished`.
//
// Ports:
//   clock        in   system clock, rising edge
//   reset        in   synchronous, active-high reset
//   start        in   one-cycle request, honoured only in IDLE
//   coffee_type  in   [2:0] drink code, sampled together with start
//   water, coffee, chocolate, milk, sugar
//                out  valve drives; at most one is high at any time
//   busy         out  high in every state except IDLE
//   finished     out  one-cycle pulse when a drink completes
//   reject       out  one-cycle pulse when start carries an invalid code
//   abort        in   (DISPENSE_ABORT_EN only) cancel a running drink
//   aborted      out  (DISPENSE_ABORT_EN only) one-cycle pulse after an abort
//
// Optional feature macro: DISPENSE_ABORT_EN adds the abort/aborted ports.
// Without the macro, a started drink always runs to completion.
//
// All outputs are registered. They are loaded from the next-state decode, so
// they line up with the state register.

module dispense_sequencer #(
    parameter int unsigned TICK_DIV = 50000,
    parameter int unsigned WATER_T  = 8,
    parameter int unsigned COFFEE_T = 3,
    parameter int unsigned CHOC_T   = 3,
    parameter int unsigned MILK_T   = 4,
    parameter int unsigned SUGAR_T  = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [2:0] coffee_type,
    output logic       water,
    output logic       coffee,
    output logic       chocolate,
    output logic       milk,
    output logic       sugar,
    output logic       busy,
    output logic       finished,
`ifdef DISPENSE_ABORT_EN
    output logic       reject,
    input  logic       abort,
    output logic       aborted
`else
    output logic       reject
`endif
);

    // Stage lengths in clock cycles.
    localparam int unsigned WATER_C  = WATER_T  * TICK_DIV;
    localparam int unsigned COFFEE_C = COFFEE_T * TICK_DIV;
    localparam int unsigned CHOC_C   = CHOC_T   * TICK_DIV;
    localparam int unsigned MILK_C   = MILK_T   * TICK_DIV;
    localparam int unsigned SUGAR_C  = SUGAR_T  * TICK_DIV;

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        max2 = (a > b) ? a : b;
    endfunction

    localparam int unsigned MAX_C = max2(max2(max2(WATER_C, COFFEE_C), max2(CHOC_C, MILK_C)), SUGAR_C);
    // The counter only ever holds (length - 1), so clog2 of the longest stage is enough.
    localparam int CNT_W = (MAX_C > 1) ? $clog2(MAX_C) : 1;

    // A zero duration or divider would make a stage impossible to time.
    generate
        if (TICK_DIV == 0 || WATER_T == 0 || COFFEE_T == 0 || CHOC_T == 0 ||
            MILK_T == 0 || SUGAR_T == 0) begin : g_param_check
            $error("dispense_sequencer: TICK_DIV and all stage lengths must be >= 1");
        end
    endgenerate

    // The stage states are numbered 1..5 so that (state - 1) is the
    // recipe bit index of that stage.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WATER  = 3'd1,
        S_COFFEE = 3'd2,
        S_CHOC   = 3'd3,
        S_MILK   = 3'd4,
        S_SUGAR  = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    // Recipe bit map: [0] water, [1] coffee, [2] choc, [3] milk, [4] sugar.
    function automatic logic [4:0] decode_recipe(input logic [2:0] code);
        case (code)
            3'b001:  decode_recipe = 5'b10011; // black: water, coffee, sugar
            3'b010:  decode_recipe = 5'b11011; // latte: water, coffee, milk, sugar
            3'b011:  decode_recipe = 5'b01111; // mocha: water, coffee, choc, milk
            3'b100:  decode_recipe = 5'b11101; // chocolate: water, choc, milk, sugar
            default: decode_recipe = 5'b00000; // invalid
        endcase
    endfunction

    function automatic logic [CNT_W-1:0] stage_load(input state_t s);
        case (s)
            S_WATER:  stage_load = CNT_W'(WATER_C  - 1);
            S_COFFEE: stage_load = CNT_W'(COFFEE_C - 1);
            S_CHOC:   stage_load = CNT_W'(CHOC_C   - 1);
            S_MILK:   stage_load = CNT_W'(MILK_C   - 1);
            S_SUGAR:  stage_load = CNT_W'(SUGAR_C  - 1);
            default:  stage_load = '0;
        endcase
    endfunction

    state_t           r_state;
    state_t           w_state_next;
    state_t           w_following;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic [4:0]       r_recipe;
    logic [4:0]       w_recipe_next;
    logic [4:0]       w_valid_recipe;
    logic             w_reject_next;
    logic             w_aborted_next;
    logic             w_abort;
    logic [4:0]       r_valve;
    logic             r_busy;
    logic             r_finished;
    logic             r_reject;

`ifdef DISPENSE_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    assign w_valid_recipe = decode_recipe(coffee_type);

    // First enabled stage after the current one, or DONE if none is left.
    // Scanning from the top down lets the lowest qualifying index win.
    always_comb begin
        int cur_idx;
        w_following = S_DONE;
        cur_idx     = int'(r_state) - 1;
        for (int i = 4; i >= 0; i--) begin
            if (i > cur_idx && r_recipe[i]) begin
                w_following = state_t'(3'(i + 1));
            end
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;
        w_recipe_next  = r_recipe;
        w_reject_next  = 1'b0;
        w_aborted_next = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (w_valid_recipe != 5'b00000) begin
                        w_recipe_next = w_valid_recipe;
                        w_state_next  = S_WATER;
                        w_cnt_next    = stage_load(S_WATER);
                    end else begin
                        w_reject_next = 1'b1;
                    end
                end
            end
            S_WATER, S_COFFEE, S_CHOC, S_MILK, S_SUGAR: begin
                if (w_abort) begin
                    w_state_next   = S_IDLE;
                    w_cnt_next     = '0;
                    w_aborted_next = 1'b1;
                end else if (r_cnt == '0) begin
                    // The next valve opens on the same edge this one closes.
                    w_state_next = w_following;
                    w_cnt_next   = stage_load(w_following);
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
                w_cnt_next   = '0;
            end
            default: begin
                w_state_next = S_IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_recipe   <= '0;
            r_busy     <= 1'b0;
            r_finished <= 1'b0;
            r_reject   <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            r_recipe   <= w_recipe_next;
            r_busy     <= (w_state_next != S_IDLE);
            r_finished <= (w_state_next == S_DONE);
            r_reject   <= w_reject_next;
        end
    end

    // One valve register per stage. Each is high exactly while the machine
    // sits in that stage, which makes two open valves impossible.
    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_valve
            always_ff @(posedge clock) begin
                if (reset) begin
                    r_valve[gi] <= 1'b0;
                end else begin
                    r_valve[gi] <= (w_state_next == state_t'(3'(gi + 1)));
                end
            end
        end
    endgenerate

`ifdef DISPENSE_ABORT_EN
    logic r_aborted;
    always_ff @(posedge clock) begin
        if (reset) begin
            r_aborted <= 1'b0;
        end else begin
            r_aborted <= w_aborted_next;
        end
    end
    assign aborted = r_aborted;
`endif

    assign water     = r_valve[0];
    assign coffee    = r_valve[1];
    assign chocolate = r_valve[2];
    assign milk      = r_valve[3];
    assign sugar     = r_valve[4];
    assign busy      = r_busy;
    assign finished  = r_finished;
    assign reject    = r_reject;

endmodule
